// File: rtl/sdram_fw_pkg.sv
// sdram_fw_pkg: FSM states, pattern codes, colour-bar table and burst sizing helper for sdram_frame_writer
package sdram_fw_pkg;

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_REQ       = 3'd1,
      S_DATA      = 3'd2,
      S_WAIT_DONE = 3'd3,
      S_NEXT      = 3'd4,
      S_DONE      = 3'd5
   } fw_state_e;

   localparam logic [1:0] PAT_BARS     = 2'd0;
   localparam logic [1:0] PAT_GRADIENT = 2'd1;
   localparam logic [1:0] PAT_CHECKER  = 2'd2;
   localparam logic [1:0] PAT_INDEX    = 2'd3;

   // Index 0 is the leftmost bar: white, yellow, cyan, green, magenta, red, blue, black
   localparam logic [7:0][15:0] BAR_RGB565 = {
      16'h0000, 16'h001F, 16'hF800, 16'hF81F,
      16'h07E0, 16'h07FF, 16'hFFE0, 16'hFFFF
   };

   // Words in the next burst: whatever is left of the line, capped at the burst size
   function automatic logic [8:0] burst_words(input logic [15:0] rem, input logic [15:0] max_words);
      return 9'((rem < max_words) ? rem : max_words);
   endfunction

endpackage

// File: rtl/sdram_fw_pattern.sv
// sdram_fw_pattern: registered RGB565 pixel generator; loads the pixel at (x,y) when i_adv is high
module sdram_fw_pattern
   import sdram_fw_pkg::*;
#(
   parameter int H_PIXELS = 640
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_adv,
   input  logic [1:0]  i_pat,
   input  logic [15:0] i_x,
   input  logic [15:0] i_y,
   input  logic [15:0] i_idx,
   output logic [15:0] o_data
);

   localparam int BAR_W = (H_PIXELS / 8 > 0) ? H_PIXELS / 8 : 1;

   logic [2:0]  w_bar;
   logic [15:0] w_pix;
   logic        w_unused_y;
   logic [15:0] r_data;

   // Bar index by threshold compare, avoiding a divider; pixels past the eighth bar stay black
   always_comb begin
      w_bar = 3'd0;
      for (int k = 1; k < 8; k++)
         if (i_x >= 16'(k * BAR_W)) w_bar = 3'(k);
   end

   assign w_pix = (i_pat == PAT_BARS)     ? BAR_RGB565[w_bar] :
                  (i_pat == PAT_GRADIENT) ? {i_x[9:5], i_x[9:4], i_x[9:5]} :
                  (i_pat == PAT_CHECKER)  ? {16{i_x[5] ^ i_y[5]}} :
                                            i_idx;

   assign w_unused_y = ^{i_y[15:6], i_y[4:0]};

   // Hold the current write word until the next pixel is requested
   always_ff @(posedge clk) begin
      if (!rst_n)     r_data <= 16'd0;
      else if (i_adv) r_data <= w_pix;
   end

   assign o_data = r_data;

endmodule

// File: rtl/sdram_frame_writer.sv
// sdram_frame_writer: fills SDRAM with a generated RGB565 test frame through the controller burst-write port.
// Optional SDRAM_FW_PINGPONG_EN alternates frames between two buffers and reports the written one on frame_sel.
module sdram_frame_writer
   import sdram_fw_pkg::*;
#(
   parameter int H_PIXELS  = 640,
   parameter int V_LINES   = 480,
   parameter int BURST_LEN = 256,
   parameter int ADDR_W    = 21,
   parameter int BASE_ADDR = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [1:0]        pattern_sel,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              frame_sel,
   output logic              wr_req,
   input  logic              wr_ack,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [8:0]        wr_len,
   output logic [15:0]       wr_data,
   input  logic              wr_data_rd,
   input  logic              wr_done
);

   localparam logic [ADDR_W-1:0] BASE0     = ADDR_W'(BASE_ADDR);
   localparam logic [15:0]       H16       = 16'(H_PIXELS);
   localparam logic [15:0]       BL16      = 16'(BURST_LEN);
   localparam logic [15:0]       LAST_Y    = 16'(V_LINES - 1);
   localparam logic [8:0]        FIRST_LEN = burst_words(H16, BL16);

   fw_state_e         r_state;
   logic [15:0]       r_x;
   logic [15:0]       r_y;
   logic [15:0]       r_px;
   logic [8:0]        r_cnt;
   logic [8:0]        r_len;
   logic [ADDR_W-1:0] r_addr;
   logic [ADDR_W-1:0] r_line_base;
   logic [15:0]       r_line_idx;
   logic [1:0]        r_pat;
   logic              r_err;

   logic              w_start_acc;
   logic              w_line_end;
   logic              w_last;
   logic [15:0]       w_nx;
   logic [15:0]       w_ny;
   logic [ADDR_W-1:0] w_nbase;
   logic [15:0]       w_nidx;
   logic [8:0]        w_nlen;
   logic [ADDR_W-1:0] w_frame_base;
   logic              w_last_word;
   logic              w_bad_rd;
   logic              w_bad_done;
   logic [15:0]       w_gen_x;
   logic [15:0]       w_gen_y;
   logic [15:0]       w_gen_lidx;
   logic              w_gen_adv;
   logic [1:0]        w_gen_pat;

   assign w_start_acc = (r_state == S_IDLE) && start;

   // Position of the following burst, evaluated while in NEXT
   assign w_line_end = (r_x + {7'd0, r_len}) == H16;
   assign w_last     = w_line_end && (r_y == LAST_Y);
   assign w_nx       = w_line_end ? 16'd0 : r_x + {7'd0, r_len};
   assign w_ny       = w_line_end ? r_y + 16'd1 : r_y;
   assign w_nbase    = w_line_end ? r_line_base + ADDR_W'(H_PIXELS) : r_line_base;
   assign w_nidx     = w_line_end ? r_line_idx + H16 : r_line_idx;
   assign w_nlen     = burst_words(H16 - w_nx, BL16);

   // Protocol checking; a wr_done landing on the last consumed word is legal
   assign w_last_word = (r_state == S_DATA) && wr_data_rd && (r_cnt == 9'd1);
   assign w_bad_rd    = wr_data_rd && (r_state != S_DATA);
   assign w_bad_done  = wr_done && (r_state != S_WAIT_DONE) && !w_last_word;

   // The generator is always primed with the word that goes out next
   assign w_gen_x    = (r_state == S_DATA) ? r_px + 16'd1 : (r_state == S_NEXT) ? w_nx : 16'd0;
   assign w_gen_y    = (r_state == S_DATA) ? r_y : (r_state == S_NEXT) ? w_ny : 16'd0;
   assign w_gen_lidx = (r_state == S_DATA) ? r_line_idx : (r_state == S_NEXT) ? w_nidx : 16'd0;
   assign w_gen_adv  = w_start_acc || ((r_state == S_DATA) && wr_data_rd) ||
                       ((r_state == S_NEXT) && !w_last);
   assign w_gen_pat  = (r_state == S_IDLE) ? pattern_sel : r_pat;

`ifdef SDRAM_FW_PINGPONG_EN
   localparam logic [ADDR_W-1:0] BASE1 = ADDR_W'(BASE_ADDR + H_PIXELS * V_LINES);
   logic r_buf;
   logic r_fsel;
   // Swap buffers as the last burst retires so frame_sel is already valid with done
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_buf  <= 1'b0;
         r_fsel <= 1'b0;
      end else if ((r_state == S_NEXT) && w_last) begin
         r_fsel <= r_buf;
         r_buf  <= ~r_buf;
      end
   end
   assign w_frame_base = r_buf ? BASE1 : BASE0;
   assign frame_sel    = r_fsel;
`else
   assign w_frame_base = BASE0;
   assign frame_sel    = 1'b0;
`endif

   // Frame sequencing: request, stream, wait for completion, step to next burst
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_x         <= 16'd0;
         r_y         <= 16'd0;
         r_px        <= 16'd0;
         r_cnt       <= 9'd0;
         r_len       <= 9'd0;
         r_addr      <= '0;
         r_line_base <= '0;
         r_line_idx  <= 16'd0;
         r_pat       <= PAT_BARS;
      end else begin
         case (r_state)
            S_IDLE:
               if (start) begin
                  r_state     <= S_REQ;
                  r_x         <= 16'd0;
                  r_y         <= 16'd0;
                  r_px        <= 16'd0;
                  r_pat       <= pattern_sel;
                  r_line_base <= w_frame_base;
                  r_line_idx  <= 16'd0;
                  r_addr      <= w_frame_base;
                  r_len       <= FIRST_LEN;
                  r_cnt       <= FIRST_LEN;
               end
            S_REQ:
               if (wr_ack) r_state <= S_DATA;
            S_DATA:
               if (wr_data_rd) begin
                  r_px  <= r_px + 16'd1;
                  r_cnt <= r_cnt - 9'd1;
                  if (r_cnt == 9'd1) r_state <= wr_done ? S_NEXT : S_WAIT_DONE;
               end
            S_WAIT_DONE:
               if (wr_done) r_state <= S_NEXT;
            S_NEXT: begin
               r_x         <= w_nx;
               r_y         <= w_ny;
               r_px        <= w_nx;
               r_line_base <= w_nbase;
               r_line_idx  <= w_nidx;
               r_addr      <= w_nbase + ADDR_W'(w_nx);
               r_len       <= w_nlen;
               r_cnt       <= w_nlen;
               r_state     <= w_last ? S_DONE : S_REQ;
            end
            S_DONE:
               r_state <= S_IDLE;
            default:
               r_state <= S_IDLE;
         endcase
      end
   end

   // Sticky protocol error, cleared by reset or a new frame
   always_ff @(posedge clk) begin
      if (!rst_n)                       r_err <= 1'b0;
      else if (w_start_acc)             r_err <= 1'b0;
      else if (w_bad_rd || w_bad_done)  r_err <= 1'b1;
   end

   sdram_fw_pattern #(
      .H_PIXELS (H_PIXELS)
   ) u_pattern (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_adv  (w_gen_adv),
      .i_pat  (w_gen_pat),
      .i_x    (w_gen_x),
      .i_y    (w_gen_y),
      .i_idx  (w_gen_lidx + w_gen_x),
      .o_data (wr_data)
   );

   assign busy    = (r_state != S_IDLE);
   assign done    = (r_state == S_DONE);
   assign err     = r_err;
   assign wr_req  = (r_state == S_REQ);
   assign wr_addr = r_addr;
   assign wr_len  = r_len;

endmodule

// File: tb/tb_sdram_frame_writer.sv
// tb_sdram_frame_writer: randomized controller model driving sdram_frame_writer, checked against a behavioural frame model
module tb_sdram_frame_writer;

   localparam int H    = 80;
   localparam int V    = 40;
   localparam int BL   = 32;
   localparam int AW   = 12;
   localparam int BASE = 3000;
   localparam int FW   = H * V;
   localparam int MSZ  = 1 << AW;

`ifdef SDRAM_FW_PINGPONG_EN
   localparam bit PP = 1'b1;
`else
   localparam bit PP = 1'b0;
`endif

   localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                        16'hF81F, 16'hF800, 16'h001F, 16'h0000};

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [1:0]    pattern_sel = 2'd0;
   logic          wr_ack = 1'b0;
   logic          wr_data_rd = 1'b0;
   logic          wr_done = 1'b0;
   logic          busy, done, err, frame_sel, wr_req;
   logic [AW-1:0] wr_addr;
   logic [8:0]    wr_len;
   logic [15:0]   wr_data;

   logic [15:0] mem [0:MSZ-1];
   int checks = 0;
   int passed = 0;
   int done_cnt = 0;
   int exp_buf = 0;

   sdram_frame_writer #(
      .H_PIXELS (H), .V_LINES (V), .BURST_LEN (BL), .ADDR_W (AW), .BASE_ADDR (BASE)
   ) dut (
      .clk (clk), .rst_n (rst_n), .start (start), .pattern_sel (pattern_sel),
      .busy (busy), .done (done), .err (err), .frame_sel (frame_sel),
      .wr_req (wr_req), .wr_ack (wr_ack), .wr_addr (wr_addr), .wr_len (wr_len),
      .wr_data (wr_data), .wr_data_rd (wr_data_rd), .wr_done (wr_done)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (done === 1'b1) done_cnt++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Expected pixel straight from the pattern definitions
   function automatic logic [15:0] pix(input int pat, input int x, input int y);
      int bar;
      bar = x / (H / 8);
      if (pat == 0) return BARS[(bar > 7) ? 7 : bar];
      if (pat == 1) return 16'((((x >> 5) & 31) << 11) | (((x >> 4) & 63) << 5) | ((x >> 5) & 31));
      if (pat == 2) return (((x / 32) % 2) != ((y / 32) % 2)) ? 16'hFFFF : 16'h0000;
      return 16'(y * H + x);
   endfunction

   task automatic burst(input int pat, input int fb, input int y, input int x0, input int b,
                        input int abort_b, input int stray_b, input int stall_b, output bit ok);
      int len, ea, t, got, bad, hold_bad, gap, dly;
      bit moved, prev_rd, stalled;
      logic [15:0] prev;
      ok = 1'b0;
      len = (H - x0 < BL) ? H - x0 : BL;
      ea = (fb + y * H + x0) % MSZ;
      t = 0; got = 0; bad = 0; hold_bad = 0; gap = 0; dly = 0;
      moved = 1'b0; stalled = 1'b0;
      while (wr_req !== 1'b1 && t < 20) begin @(negedge clk); t++; end
      chk("req_wait", 32'(t < 20), 1);
      if (t >= 20) return;
      chk("addr", 32'(wr_addr), ea);
      chk("len", 32'(wr_len), len);
      if (b == stray_b) begin
         wr_done = 1'b1; @(negedge clk); wr_done = 1'b0;
         chk("err_stray_done", 32'(err), 1);
      end
      repeat ($urandom_range(0, 2)) begin
         @(negedge clk);
         if (wr_req !== 1'b1 || wr_addr !== AW'(ea) || wr_len !== 9'(len)) moved = 1'b1;
      end
      wr_ack = 1'b1; @(negedge clk); wr_ack = 1'b0;
      chk("req_drop", 32'(wr_req), 0);
      chk("req_stable", 32'(moved), 0);
      prev = wr_data; prev_rd = 1'b1;
      while (got < len) begin
         if (!prev_rd && wr_data !== prev) hold_bad++;
         if (b == abort_b && got == len / 2) begin
            rst_n = 1'b0; @(negedge clk);
            chk("rst_req", 32'(wr_req), 0);
            chk("rst_busy", 32'(busy), 0);
            chk("rst_done", 32'(done), 0);
            rst_n = 1'b1;
            exp_buf = 0;
            return;
         end
         if (b == stall_b && got == 3 && !stalled) begin
            stalled = 1'b1;
            prev = wr_data;
            repeat (5) begin @(negedge clk); chk("stall_hold", 32'(wr_data), 32'(prev)); end
         end
         wr_data_rd = ($urandom_range(0, 3) != 0) || gap >= 3;
         if (wr_data_rd) begin
            if (wr_data !== pix(pat, x0 + got, y)) bad++;
            mem[(ea + got) % MSZ] = wr_data;
            got++; gap = 0;
            if (got == len) begin
               dly = $urandom_range(0, 3);
               if (dly == 0) wr_done = 1'b1;
            end
         end else gap++;
         prev = wr_data; prev_rd = wr_data_rd;
         @(negedge clk);
         wr_data_rd = 1'b0; wr_done = 1'b0;
      end
      if (dly > 0) begin
         repeat (dly - 1) @(negedge clk);
         wr_done = 1'b1; @(negedge clk); wr_done = 1'b0;
      end
      chk("data", bad, 0);
      chk("hold", hold_bad, 0);
      ok = 1'b1;
   endtask

   task automatic frame(input int pat, input int abort_b, input int stray_b, input int stall_b, output int fb);
      int b, t, d0;
      bit ok;
      b = 0; ok = 1'b1; d0 = done_cnt;
      fb = (PP && exp_buf != 0) ? BASE + FW : BASE;
      start = 1'b1; pattern_sel = 2'(pat);
      @(negedge clk);
      start = 1'b0; pattern_sel = 2'($urandom);
      chk("req_after_start", 32'(wr_req), 1);
      chk("err_clear", 32'(err), 0);
      for (int y = 0; y < V && ok; y++)
         for (int x0 = 0; x0 < H && ok; x0 += BL) begin
            burst(pat, fb, y, x0, b, abort_b, stray_b, stall_b, ok);
            b++;
         end
      if (!ok) return;
      t = 0;
      while (done !== 1'b1 && t < 10) begin @(negedge clk); t++; end
      chk("done_wait", 32'(t < 10), 1);
      chk("frame_sel", 32'(frame_sel), PP ? exp_buf : 0);
      start = 1'b1; @(negedge clk); start = 1'b0;
      chk("start_with_done", 32'(busy), 0);
      chk("done_once", done_cnt - d0, 1);
      if (PP) exp_buf ^= 1;
   endtask

   initial begin
      int fb, d;
      repeat (3) @(negedge clk);
      chk("rst_busy0", 32'(busy), 0);
      chk("rst_done0", 32'(done), 0);
      chk("rst_err0", 32'(err), 0);
      chk("rst_wr_req0", 32'(wr_req), 0);
      chk("rst_wr_addr0", 32'(wr_addr), 0);
      chk("rst_wr_len0", 32'(wr_len), 0);
      chk("rst_wr_data0", 32'(wr_data), 0);
      chk("rst_frame_sel0", 32'(frame_sel), 0);
      rst_n = 1'b1;
      @(negedge clk);
      wr_data_rd = 1'b1; @(negedge clk); wr_data_rd = 1'b0;
      chk("err_stray_rd", 32'(err), 1);
      wr_done = 1'b1; @(negedge clk); wr_done = 1'b0;
      chk("err_sticky", 32'(err), 1);
      chk("idle_busy", 32'(busy), 0);

      frame(3, -1, -1, 5, fb);
      chk("line1_word", 32'(mem[(fb + H) % MSZ]), 32'h0050);
      chk("last_word", 32'(mem[(fb + FW - 1) % MSZ]), 32'h0C7F);

      frame(0, -1, -1, -1, fb);
      chk("bar_x0", 32'(mem[fb % MSZ]), 32'hFFFF);
      chk("bar_x10", 32'(mem[(fb + 10) % MSZ]), 32'hFFE0);
      chk("bar_x79", 32'(mem[(fb + 79) % MSZ]), 32'h0000);

      frame(1, -1, -1, -1, fb);
      frame(2, -1, -1, -1, fb);

      frame(3, 40, -1, -1, fb);
      d = done_cnt;
      repeat (5) @(negedge clk);
      chk("abort_no_done", done_cnt - d, 0);
      chk("abort_idle", 32'(busy), 0);

      frame($urandom_range(0, 3), -1, -1, -1, fb);
      frame($urandom_range(0, 3), -1, 7, -1, fb);
      chk("err_sticky_end", 32'(err), 1);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
